// File: rtl/fetch_thread_sched_pkg.sv
// Shared types for the multithreaded fetch stage.
// Thread states, fetch bundle and per-thread boot addresses.
package common;

  localparam int n_threads = 8;
  localparam int tid_w     = 3;

  typedef logic [31:0]      vptr_t;
  typedef logic [7:0]       ppn_t;
  typedef logic [19:0]      pptr_t;
  typedef logic [31:0]      instr_t;
  typedef logic [tid_w-1:0] tid_t;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    PARKED
  } thread_state_t;

  typedef struct packed {
    tid_t   tid;
    vptr_t  pc;
    instr_t instr;
    logic   exc;
  } fetch_out_t;

  // Threads boot 256 bytes apart, thread 0 highest.
  function automatic vptr_t boot_pc(input int i);
    return 32'h1700 - 32'(i) * 32'h100;
  endfunction

endpackage

// File: rtl/fetch_thread_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first request found cyclically after last_i.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int TW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [TW-1:0] last_i,
  output logic [N-1:0]  grant_oh_o,
  output logic [TW-1:0] grant_idx_o,
  output logic          grant_valid_o
);

  always_comb begin
    grant_oh_o    = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (int'(last_i) + k) % N;
      if (!grant_valid_o && req_i[j]) begin
        grant_valid_o  = 1'b1;
        grant_idx_o    = TW'(j);
        grant_oh_o[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_thread_sched.sv
// Multithreaded fetch: round-robin thread pick, ITLB + icache
// lookup in the pick cycle, one registered slot toward decode.
module fetch_thread_sched
  import common::*;
#(
  parameter int N_THREADS = n_threads
) (
  input  logic        clk,
  input  logic        rst,
  output vptr_t       itlb_vaddr,
  output logic        itlb_req,
  input  logic        itlb_hit,
  input  ppn_t        itlb_ppn,
  output logic        ic_req,
  output pptr_t       ic_addr,
  output tid_t        ic_req_tid,
  input  logic        ic_hit,
  input  instr_t      ic_word,
  input  logic        ic_fill_valid,
  input  tid_t        ic_fill_tid,
  input  logic        redir_valid,
  input  tid_t        redir_tid,
  input  vptr_t       redir_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output tid_t        out_tid,
  output vptr_t       out_pc,
  output instr_t      out_instr,
  output logic        out_exc
);

  thread_state_t state_q [N_THREADS];
  thread_state_t state_d [N_THREADS];
  vptr_t         pc_q    [N_THREADS];
  vptr_t         pc_d    [N_THREADS];
  tid_t          rr_q, rr_d;
  fetch_out_t    out_q, out_d;
  logic          outv_q, outv_d;

  logic [N_THREADS-1:0] elig;
  logic [N_THREADS-1:0] gnt_oh;
  tid_t                 gidx;
  logic                 gvalid;
  logic                 slot_free;
  logic                 pick;
  logic                 xfer;
  logic                 tlb_miss;
  logic                 ic_miss;
  logic                 fetch_hit;

  // A thread being redirected this cycle sits out the pick.
  always_comb begin
    for (int i = 0; i < N_THREADS; i++) begin
      elig[i] = (state_q[i] == RUN) &&
                !(redir_valid && redir_tid == tid_t'(i));
    end
  end

  rr_arbiter #(
    .N  (N_THREADS),
    .TW (tid_w)
  ) u_arb (
    .req_i         (elig),
    .last_i        (rr_q),
    .grant_oh_o    (gnt_oh),
    .grant_idx_o   (gidx),
    .grant_valid_o (gvalid)
  );

  assign slot_free = !outv_q || out_ready;
  assign xfer      = outv_q && out_ready;
  assign pick      = !rst && slot_free && gvalid;

  always_comb begin
    itlb_vaddr = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      if (gnt_oh[i]) itlb_vaddr = itlb_vaddr | pc_q[i];
    end
  end

  assign itlb_req   = pick;
  assign ic_req     = pick && itlb_hit;
  assign ic_addr    = {itlb_ppn, itlb_vaddr[11:0]};
  assign ic_req_tid = gidx;

  assign tlb_miss  = !itlb_hit;
  assign ic_miss   = itlb_hit && !ic_hit;
  assign fetch_hit = itlb_hit && ic_hit;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rr_d    = rr_q;
    out_d   = out_q;
    outv_d  = outv_q;
    if (xfer) outv_d = 1'b0;
    if (pick) begin
      unique case (1'b1)
        tlb_miss: begin
          out_d         = '{tid: gidx, pc: pc_q[gidx],
                            instr: '0, exc: 1'b1};
          outv_d        = 1'b1;
          state_d[gidx] = PARKED;
          rr_d          = gidx;
        end
        ic_miss: begin
          state_d[gidx] = MEM_WAIT;
        end
        fetch_hit: begin
          out_d      = '{tid: gidx, pc: pc_q[gidx],
                         instr: ic_word, exc: 1'b0};
          outv_d     = 1'b1;
          pc_d[gidx] = pc_q[gidx] + 32'd4;
          rr_d       = gidx;
        end
      endcase
    end
    if (ic_fill_valid && state_q[ic_fill_tid] == MEM_WAIT) begin
      state_d[ic_fill_tid] = RUN;
    end
    // Redirect overrides fill and can kill a stalled slot entry.
    if (redir_valid) begin
      pc_d[redir_tid]    = redir_pc;
      state_d[redir_tid] = RUN;
      if (outv_q && out_q.tid == redir_tid && !xfer) outv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_THREADS; i++) begin
        state_q[i] <= RUN;
        pc_q[i]    <= boot_pc(i);
      end
      rr_q   <= tid_t'(N_THREADS - 1);
      out_q  <= '0;
      outv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rr_q    <= rr_d;
      out_q   <= out_d;
      outv_q  <= outv_d;
    end
  end

  assign out_valid = outv_q;
  assign out_tid   = out_q.tid;
  assign out_pc    = out_q.pc;
  assign out_instr = out_q.instr;
  assign out_exc   = out_q.exc;

endmodule
